y_muldiv: RTL and testbench

Y_MULDIV -- requirements
Module: y_muldiv

---
 rtl/y_muldiv.sv | 203 ++++++++++++++++++++
 tb/tb_y_muldiv.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_muldiv.sv
// y_muldiv: iterative multiplier/divider that retires one operand bit per cycle.
// Define Y_MULDIV_SIGNED_EN to honour sgn (two's complement operands); otherwise unsigned only.
module y_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] md_q, md_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic             accept;

`ifdef Y_MULDIV_SIGNED_EN
    logic neg_a_q, neg_a_d;
    logic neg_b_q, neg_b_d;
    logic neg_a, neg_b;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // The core only ever sees magnitudes; signs are reapplied in FIX.
    assign neg_a = sgn & a[WIDTH-1];
    assign neg_b = sgn & b[WIDTH-1];
    assign mag_a = cond_neg(a, neg_a);
    assign mag_b = cond_neg(b, neg_b);
`else
    logic unused_sgn;
    assign unused_sgn = sgn;
    assign mag_a      = a;
    assign mag_b      = b;
`endif

    assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !flush;

    // Shift-add step: hi:lo holds partial product (hi) and remaining multiplier bits (lo).
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : {(WIDTH+1){1'b0}});

    // Restoring divide step: hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, md_q});
    assign div_sub   = div_shift[WIDTH-1:0] - md_q;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, res_sel;

`ifdef Y_MULDIV_SIGNED_EN
    assign prod_fix = cond_neg2({hi_q, lo_q}, neg_a_q ^ neg_b_q);
    assign quot_fix = cond_neg(lo_q, neg_a_q ^ neg_b_q);
    assign rem_fix  = cond_neg(hi_q, neg_a_q);
`else
    assign prod_fix = {hi_q, lo_q};
    assign quot_fix = lo_q;
    assign rem_fix  = hi_q;
`endif

    // A zero divisor leaves the remainder equal to the dividend naturally; only the quotient is forced.
    always_comb begin
        case (op_q)
            OP_MUL:  res_sel = prod_fix[WIDTH-1:0];
            OP_MULH: res_sel = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV:  res_sel = dz_q ? {WIDTH{1'b1}} : quot_fix;
            default: res_sel = rem_fix;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        md_d       = md_q;
        dz_d       = dz_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
`ifdef Y_MULDIV_SIGNED_EN
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
`endif
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (op_q[1]) begin
                        hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], div_ge};
                    end else begin
                        hi_d = mul_sum[WIDTH:1];
                        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                    end
                end
                S_FIX: begin
                    result_d   = res_sel;
                    div_zero_d = dz_q;
                    state_d    = S_DONE;
                end
                default: begin
                    if (accept) begin
                        op_d    = op;
                        dz_d    = op[1] && (b == '0);
                        hi_d    = '0;
                        lo_d    = op[1] ? mag_a : mag_b;
                        md_d    = op[1] ? mag_b : mag_a;
                        cnt_d   = '0;
                        state_d = S_RUN;
`ifdef Y_MULDIV_SIGNED_EN
                        neg_a_d = neg_a;
                        neg_b_d = neg_b;
`endif
                    end else if (state_q == S_DONE) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            md_q       <= '0;
            dz_q       <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
`ifdef Y_MULDIV_SIGNED_EN
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            md_q       <= md_d;
            dz_q       <= dz_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
`ifdef Y_MULDIV_SIGNED_EN
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
`endif
        end
    end

    assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_y_muldiv.sv
// Directed bench for y_muldiv (WIDTH=32) with an expected-result queue popped on each done pulse.
module tb_y_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_zero;

    typedef struct packed {
        logic        dz;
        logic [31:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    y_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .sgn      (sgn),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: plain arithmetic operators on widened values.
    function automatic logic [32:0] model(input logic [1:0] o, input logic s,
                                          input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] q, r;
        logic        use_s;
        longint      sp;
`ifdef Y_MULDIV_SIGNED_EN
        use_s = s;
`else
        use_s = 1'b0;
`endif
        if (use_s) begin
            sp = longint'($signed(x)) * longint'($signed(y));
            p  = sp;
            if (y == 32'd0) begin
                q = 32'hFFFF_FFFF; r = x;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q = x; r = 32'd0;
            end else begin
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
            end
        end else begin
            p = {32'd0, x} * {32'd0, y};
            q = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            r = (y == 32'd0) ? x : x % y;
        end
        case (o)
            2'd0:    return {1'b0, p[31:0]};
            2'd1:    return {1'b0, p[63:32]};
            2'd2:    return {y == 32'd0, q};
            default: return {y == 32'd0, r};
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic edz);
        exp_t e;
        start = 1'b1;
        op    = o;
        sgn   = s;
        a     = x;
        b     = y;
        e.dz  = edz;
        e.res = er;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int elapsed);
        int   cyc;
        int   bcnt;
        bit   seen;
        exp_t e;
        cyc  = elapsed;
        bcnt = elapsed;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) seen = 1'b1;
            else if (busy) bcnt++;
        end
        chk({tag, " latency"}, cyc, 34);
        chk({tag, " busy cycles"}, bcnt, 33);
        chk({tag, " busy at done"}, busy, 0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (seen) begin
                chk({tag, " result"}, result, e.res);
                chk({tag, " div_zero"}, div_zero, e.dz);
            end
        end
    endtask

    initial begin
        logic [32:0] m;
        logic [1:0]  ro;
        logic        rs;
        logic [31:0] ra, rb;
        int          dn;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'd0;
        sgn   = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset div_zero", div_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'd0, 1'b0, 32'd7, 32'd6, 32'd42, 1'b0);
        wait_done("mul 7x6", 0);
        @(negedge clk);
        chk("done single pulse", done, 0);

        issue(2'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        wait_done("mulh max", 0);
        issue(2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done("mul max", 0);

        issue(2'd2, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
        wait_done("div 100/7", 0);
        issue(2'd3, 1'b0, 32'd100, 32'd7, 32'd2, 1'b0);
        wait_done("rem 100/7 b2b", 0);

        issue(2'd2, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        wait_done("div 5/0", 0);
        issue(2'd3, 1'b0, 32'd5, 32'd0, 32'd5, 1'b1);
        wait_done("rem 5/0", 0);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
            m  = model(ro, rs, ra, rb);
            issue(ro, rs, ra, rb, m[31:0], m[32]);
            wait_done($sformatf("rand%0d", i), 0);
        end

        // A start raised mid-operation must not disturb the operation in flight.
        issue(2'd2, 1'b0, 32'd77, 32'd0, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = 2'd0;
        a     = 32'd3;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("ignored start busy", busy, 1);
        wait_done("ignored start", 11);
        @(negedge clk);

        issue(2'd2, 1'b0, 32'd1000, 32'd10, 32'd100, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        void'(sb_q.pop_back());
        chk("flush busy", busy, 0);
        issue(2'd0, 1'b0, 32'd2, 32'd2, 32'd4, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        void'(sb_q.pop_back());
        chk("flush beats start", busy, 0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("flush no done", dn, 0);
        chk("flush result kept", result, 32'hFFFF_FFFF);
        chk("flush div_zero kept", div_zero, 1);

        issue(2'd0, 1'b0, 32'd7, 32'd6, 32'd42, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midop reset busy", busy, 0);
        chk("midop reset done", done, 0);
        chk("midop reset result", result, 0);
        chk("midop reset div_zero", div_zero, 0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'd0, 1'b0, 32'd9, 32'd9, 32'd81, 1'b0);
        wait_done("first after reset", 0);

`ifdef Y_MULDIV_SIGNED_EN
        issue(2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        wait_done("sdiv overflow", 0);
        issue(2'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        wait_done("srem overflow", 0);
        issue(2'd2, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        wait_done("sdiv -7/2", 0);
        issue(2'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        wait_done("srem -7/2", 0);
        issue(2'd1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        wait_done("smulh -1x1", 0);
        issue(2'd2, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1);
        wait_done("sdiv -7/0", 0);
        issue(2'd3, 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);
        wait_done("srem -7/0", 0);
`endif

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
